id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage RV32 core. Captures decode outputs: PC, register-file
//  read data, the 32-bit sign-extended immediate from the LW/SW/ADDI immediate generator, and
//  register indices. Derives the EX/MEM control bits and presents them to EX.
//  Detects load-use hazards against the instruction it holds and inserts a one-cycle bubble.
// PARAMETERS
//  XLEN        32  datapath width (PC, rs data, immediate)
//  REG_ADDR_W  5   register index width
//  CNT_W       16  bubble counter width (used only with ID_EX_BUBBLE_CNT_EN)
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           async active-low reset
//  id_valid       in   1           ID holds a valid instruction
//  id_pc          in   XLEN        PC of ID instruction
//  id_opcode      in   7           instr[6:0]
//  id_funct3      in   3           instr[14:12]
//  id_rs1,id_rs2  in   REG_ADDR_W  source indices
//  id_rd          in   REG_ADDR_W  destination index
//  id_rs1_data    in   XLEN        RF read port 1
//  id_rs2_data    in   XLEN        RF read port 2
//  id_imm         in   XLEN        sign-extended immediate
//  stall          in   1           downstream hold: freeze all registers
//  flush          in   1           branch/redirect kill: load bubble
//  hazard_stall   out  1           load-use detected; IF/ID and PC must hold (combinational)
//  ex_valid       out  1           EX instruction valid
//  ex_pc,ex_rs1_data,ex_rs2_data,ex_imm  out XLEN  registered copies
//  ex_opcode,ex_funct3,ex_rs1,ex_rs2,ex_rd  out  registered copies
//  ex_reg_write   out  1           set for LW(0000011), ADDI(0010011), R-type(0110011)
//  ex_mem_read    out  1           set for LW
//  ex_mem_write   out  1           set for SW(0100011)
//  ex_alu_src_imm out  1           set for LW, SW, ADDI
//  ex_bubble_cnt  out  CNT_W       bubbles inserted (saturating)
// BEHAVIOUR
//  - Reset (rst_n=0, async): every registered output = 0; hazard_stall = 0.
//  - Latency 1 cycle ID->EX. Control bits are decoded from id_opcode before registering;
//    control bits = 0 whenever id_valid=0; unlisted opcodes give all control bits 0.
//  - rs usage: LW/ADDI use rs1 only; SW and R-type use rs1 and rs2; other opcodes use none.
//  - hazard_stall = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & !flush &
//    ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
//  - Per-edge priority, highest first:
//    1 flush: bubble.
//    2 stall: hold every register unchanged. hazard_stall is still evaluated on the held contents.
//    3 hazard_stall: bubble. The ID instruction is re-presented next cycle by the held IF/ID.
//    4 else: load ID fields.
//  - Bubble: ex_valid and all control bits = 0; ex_opcode, ex_rd and all data fields = 0.
//  - A hazard lasts exactly one cycle: the bubble clears ex_mem_read.
//  - Back-to-back LW then dependent LW: one bubble only.
//  - rd = x0 never triggers a hazard.
//  - Reset asserted mid-operation clears the stage immediately; the first edge after release loads normally.
// CONFIGURATION
//  ID_EX_BUBBLE_CNT_EN defined: ex_bubble_cnt increments by 1 on each edge where a bubble is
//    inserted (flush or hazard) and stall=0; saturates at 2^CNT_W-1; reset to 0.
//  Not defined: ex_bubble_cnt tied to 0; no counter flops.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> all ex_* = 0 and hazard_stall = 0 asynchronously, before the next clk edge.
//  2 Load-use: EX holds LW x5,0(x1); ID holds ADDI x6,x5,4 -> hazard_stall=1 for 1 cycle; next
//    cycle ex_valid=0; following cycle ex_opcode=0010011, ex_imm=32'h4, ex_reg_write=1.
//  3 No false hazard: LW x0 followed by ADDI x6,x0,1 -> hazard_stall=0.
//    LW x5 followed by SW x7,8(x2) -> hazard_stall=0. LW x5 followed by SW x5,8(x2) -> hazard_stall=1.
//  4 Flush and hazard together: conditions of test 2 plus flush=1 -> hazard_stall=0; EX is a bubble next cycle.
//  5 Stall: stall=1 for 3 cycles with new ID inputs -> ex_* unchanged; the first edge after
//    release loads the current ID fields.
//  6 With ID_EX_BUBBLE_CNT_EN and CNT_W=2: 5 bubbles -> ex_bubble_cnt = 1,2,3,3,3.
//    Without the macro -> ex_bubble_cnt = 0 throughout.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: decode-side fields and control in, registered EX-side copies out.
interface id_ex_stage_reg_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    logic                  id_valid;
    logic [XLEN-1:0]       id_pc;
    logic [6:0]            id_opcode;
    logic [2:0]            id_funct3;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [XLEN-1:0]       id_imm;
    logic                  stall;
    logic                  flush;

    logic                  hazard_stall;
    logic                  ex_valid;
    logic [XLEN-1:0]       ex_pc;
    logic [6:0]            ex_opcode;
    logic [2:0]            ex_funct3;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [XLEN-1:0]       ex_rs1_data;
    logic [XLEN-1:0]       ex_rs2_data;
    logic [XLEN-1:0]       ex_imm;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_alu_src_imm;
    logic [CNT_W-1:0]      ex_bubble_cnt;

    modport master (
        output id_valid, id_pc, id_opcode, id_funct3, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, stall, flush,
        input  hazard_stall, ex_valid, ex_pc, ex_opcode, ex_funct3, ex_rs1, ex_rs2, ex_rd,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_alu_src_imm, ex_bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_opcode, id_funct3, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, stall, flush,
        output hazard_stall, ex_valid, ex_pc, ex_opcode, ex_funct3, ex_rs1, ex_rs2, ex_rd,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_alu_src_imm, ex_bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with control decode and load-use bubble insertion.
// Optional saturating bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage_reg #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input logic                clk,
    input logic                rst_n,
    id_ex_stage_reg_if.slave   id_ex_io
);
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpReg   = 7'b0110011;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  alu_src_imm;
    } ex_t;

    ex_t  ex_q, ex_d, id_load;
    logic is_lw, is_addi, is_sw, is_rtype;
    logic uses_rs1, uses_rs2;
    logic hazard;

    always_comb begin
        is_lw    = (id_ex_io.id_opcode == OpLoad);
        is_addi  = (id_ex_io.id_opcode == OpImm);
        is_sw    = (id_ex_io.id_opcode == OpStore);
        is_rtype = (id_ex_io.id_opcode == OpReg);
        uses_rs1 = is_lw | is_addi | is_sw | is_rtype;
        uses_rs2 = is_sw | is_rtype;
    end

    // Only a load sitting in EX can hazard; its data is not ready until MEM.
    always_comb begin
        hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                 id_ex_io.id_valid & ~id_ex_io.flush &
                 ((uses_rs1 & (id_ex_io.id_rs1 == ex_q.rd)) |
                  (uses_rs2 & (id_ex_io.id_rs2 == ex_q.rd)));
    end

    always_comb begin
        id_load             = '0;
        id_load.valid       = id_ex_io.id_valid;
        id_load.pc          = id_ex_io.id_pc;
        id_load.opcode      = id_ex_io.id_opcode;
        id_load.funct3      = id_ex_io.id_funct3;
        id_load.rs1         = id_ex_io.id_rs1;
        id_load.rs2         = id_ex_io.id_rs2;
        id_load.rd          = id_ex_io.id_rd;
        id_load.rs1_data    = id_ex_io.id_rs1_data;
        id_load.rs2_data    = id_ex_io.id_rs2_data;
        id_load.imm         = id_ex_io.id_imm;
        id_load.reg_write   = id_ex_io.id_valid & (is_lw | is_addi | is_rtype);
        id_load.mem_read    = id_ex_io.id_valid & is_lw;
        id_load.mem_write   = id_ex_io.id_valid & is_sw;
        id_load.alu_src_imm = id_ex_io.id_valid & (is_lw | is_sw | is_addi);
    end

    always_comb begin
        ex_d = ex_q;
        if (id_ex_io.flush) begin
            ex_d = '0;
        end else if (id_ex_io.stall) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d = '0;
        end else begin
            ex_d = id_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((id_ex_io.flush | hazard) & ~id_ex_io.stall & (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign id_ex_io.ex_bubble_cnt = bubble_cnt_q;
`else
    assign id_ex_io.ex_bubble_cnt = '0;
`endif

    assign id_ex_io.hazard_stall   = hazard;
    assign id_ex_io.ex_valid       = ex_q.valid;
    assign id_ex_io.ex_pc          = ex_q.pc;
    assign id_ex_io.ex_opcode      = ex_q.opcode;
    assign id_ex_io.ex_funct3      = ex_q.funct3;
    assign id_ex_io.ex_rs1         = ex_q.rs1;
    assign id_ex_io.ex_rs2         = ex_q.rs2;
    assign id_ex_io.ex_rd          = ex_q.rd;
    assign id_ex_io.ex_rs1_data    = ex_q.rs1_data;
    assign id_ex_io.ex_rs2_data    = ex_q.rs2_data;
    assign id_ex_io.ex_imm         = ex_q.imm;
    assign id_ex_io.ex_reg_write   = ex_q.reg_write;
    assign id_ex_io.ex_mem_read    = ex_q.mem_read;
    assign id_ex_io.ex_mem_write   = ex_q.mem_write;
    assign id_ex_io.ex_alu_src_imm = ex_q.alu_src_imm;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, decode, load-use hazards, flush, stall, bubble count.
module tb_id_ex_stage_reg;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_ADD = 7'b0010011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_stage_reg_if #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(2)) bus ();

    id_ex_stage_reg #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .id_ex_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [6:0] op,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] imm);
        bus.id_valid    = v;
        bus.id_pc       = pc;
        bus.id_opcode   = op;
        bus.id_funct3   = 3'b010;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_rs1_data = pc ^ 32'hA5A5_0000;
        bus.id_rs2_data = pc ^ 32'h0000_5A5A;
        bus.id_imm      = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.stall  = 1'b0;
        bus.flush  = 1'b0;
        set_id(1'b0, 32'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
        #2;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h0 || bus.ex_imm !== 32'h0) begin
            errors++;
            $display("FAIL reset_init: valid=%b pc=%h imm=%h exp 0", bus.ex_valid, bus.ex_pc,
                     bus.ex_imm);
        end
        checks++;
        if (bus.hazard_stall !== 1'b0 || bus.ex_bubble_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_init_hz: hz=%b cnt=%0d exp 0/0", bus.hazard_stall,
                     bus.ex_bubble_cnt);
        end
        #2 rst_n = 1'b1;
        // LW x5,0(x1) into EX, then dependent ADDI in ID, then reset mid-cycle.
        set_id(1'b1, 32'h40, OP_LW, 5'd1, 5'd0, 5'd5, 32'h0);
        tick();
        set_id(1'b1, 32'h44, OP_ADD, 5'd5, 5'd0, 5'd6, 32'h4);
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_hz: got %b exp 1", bus.hazard_stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.ex_rd !== 5'd0 ||
            bus.ex_pc !== 32'h0 || bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: valid=%b mr=%b rd=%0d pc=%h hz=%b exp all 0",
                     bus.ex_valid, bus.ex_mem_read, bus.ex_rd, bus.ex_pc, bus.hazard_stall);
        end
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_opcode !== OP_ADD || bus.ex_pc !== 32'h44) begin
            errors++;
            $display("FAIL reset_release_load: valid=%b op=%b pc=%h exp 1/0010011/44",
                     bus.ex_valid, bus.ex_opcode, bus.ex_pc);
        end
    endtask

    task automatic test_decode();
        set_id(1'b1, 32'h80, OP_SW, 5'd2, 5'd7, 5'd8, 32'h8);
        tick();
        checks++;
        if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src_imm} !== 4'b0011 ||
            bus.ex_rs2_data !== (32'h80 ^ 32'h0000_5A5A) || bus.ex_rs2 !== 5'd7) begin
            errors++;
            $display("FAIL decode_sw: ctl=%b rs2d=%h rs2=%0d exp 0011/%h/7",
                     {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src_imm},
                     bus.ex_rs2_data, 32'h80 ^ 32'h0000_5A5A, bus.ex_rs2);
        end
        set_id(1'b1, 32'h84, OP_R, 5'd3, 5'd4, 5'd9, 32'h0);
        tick();
        checks++;
        if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src_imm} !== 4'b1000 ||
            bus.ex_rd !== 5'd9 || bus.ex_funct3 !== 3'b010) begin
            errors++;
            $display("FAIL decode_r: ctl=%b rd=%0d f3=%b exp 1000/9/010",
                     {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src_imm},
                     bus.ex_rd, bus.ex_funct3);
        end
        set_id(1'b1, 32'h88, OP_BR, 5'd3, 5'd4, 5'd0, 32'h10);
        tick();
        checks++;
        if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src_imm} !== 4'b0000 ||
            bus.ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL decode_unlisted: ctl=%b valid=%b exp 0000/1",
                     {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src_imm},
                     bus.ex_valid);
        end
        set_id(1'b0, 32'h8C, OP_LW, 5'd1, 5'd0, 5'd5, 32'h0);
        tick();
        checks++;
        if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src_imm} !== 4'b0000 ||
            bus.ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL decode_invalid: ctl=%b valid=%b exp 0000/0",
                     {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src_imm},
                     bus.ex_valid);
        end
    endtask

    task automatic test_load_use();
        set_id(1'b1, 32'h100, OP_LW, 5'd1, 5'd0, 5'd5, 32'h0);
        tick();
        set_id(1'b1, 32'h104, OP_ADD, 5'd5, 5'd0, 5'd6, 32'h4);
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_hz: got %b exp 1", bus.hazard_stall);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_opcode !== 7'h0 || bus.ex_pc !== 32'h0 ||
            bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble: valid=%b op=%b pc=%h hz=%b exp 0/0/0/0",
                     bus.ex_valid, bus.ex_opcode, bus.ex_pc, bus.hazard_stall);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_opcode !== OP_ADD || bus.ex_imm !== 32'h4 ||
            bus.ex_reg_write !== 1'b1 || bus.ex_rd !== 5'd6) begin
            errors++;
            $display("FAIL load_use_addi: valid=%b op=%b imm=%h rw=%b rd=%0d exp 1/0010011/4/1/6",
                     bus.ex_valid, bus.ex_opcode, bus.ex_imm, bus.ex_reg_write, bus.ex_rd);
        end
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, 32'h200, OP_LW, 5'd1, 5'd0, 5'd5, 32'h0);
        tick();
        set_id(1'b1, 32'h204, OP_LW, 5'd5, 5'd0, 5'd6, 32'h0);
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hz: got %b exp 1", bus.hazard_stall);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble: valid=%b hz=%b exp 0/0", bus.ex_valid, bus.hazard_stall);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_mem_read !== 1'b1 || bus.ex_rd !== 5'd6 ||
            bus.ex_pc !== 32'h204) begin
            errors++;
            $display("FAIL b2b_second_lw: valid=%b mr=%b rd=%0d pc=%h exp 1/1/6/204",
                     bus.ex_valid, bus.ex_mem_read, bus.ex_rd, bus.ex_pc);
        end
    endtask

    task automatic test_no_false_hazard();
        set_id(1'b1, 32'h300, OP_LW, 5'd1, 5'd0, 5'd0, 32'h0);
        tick();
        set_id(1'b1, 32'h304, OP_ADD, 5'd0, 5'd0, 5'd6, 32'h1);
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL nofalse_x0: got %b exp 0", bus.hazard_stall);
        end
        set_id(1'b1, 32'h308, OP_LW, 5'd1, 5'd0, 5'd5, 32'h0);
        tick();
        set_id(1'b1, 32'h30C, OP_SW, 5'd2, 5'd7, 5'd8, 32'h8);
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL nofalse_sw_x7: got %b exp 0", bus.hazard_stall);
        end
        set_id(1'b1, 32'h30C, OP_SW, 5'd2, 5'd5, 5'd8, 32'h8);
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL hazard_sw_rs2: got %b exp 1", bus.hazard_stall);
        end
        // ADDI ignores rs2, so a matching rs2 field must not hazard.
        set_id(1'b1, 32'h310, OP_ADD, 5'd3, 5'd5, 5'd8, 32'h8);
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL nofalse_addi_rs2: got %b exp 0", bus.hazard_stall);
        end
    endtask

    task automatic test_flush_hazard();
        set_id(1'b1, 32'h400, OP_LW, 5'd1, 5'd0, 5'd5, 32'h0);
        tick();
        set_id(1'b1, 32'h404, OP_ADD, 5'd5, 5'd0, 5'd6, 32'h4);
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_hz: got %b exp 0", bus.hazard_stall);
        end
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_opcode !== 7'h0 || bus.ex_rd !== 5'd0 ||
            bus.ex_imm !== 32'h0 || bus.ex_mem_read !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble: valid=%b op=%b rd=%0d imm=%h mr=%b exp all 0",
                     bus.ex_valid, bus.ex_opcode, bus.ex_rd, bus.ex_imm, bus.ex_mem_read);
        end
    endtask

    task automatic test_stall();
        set_id(1'b1, 32'h500, OP_LW, 5'd1, 5'd0, 5'd5, 32'h10);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 32'h600 + 32'(4 * i), OP_R, 5'd5, 5'd2, 5'd9, 32'h0);
            #1;
            checks++;
            if (bus.hazard_stall !== 1'b1) begin
                errors++;
                $display("FAIL stall_hz_held[%0d]: got %b exp 1", i, bus.hazard_stall);
            end
            tick();
            checks++;
            if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h500 || bus.ex_opcode !== OP_LW ||
                bus.ex_imm !== 32'h10 || bus.ex_rd !== 5'd5) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h op=%b imm=%h rd=%0d exp 1/500/LW/10/5",
                         i, bus.ex_valid, bus.ex_pc, bus.ex_opcode, bus.ex_imm, bus.ex_rd);
            end
        end
        bus.stall = 1'b0;
        set_id(1'b1, 32'h700, OP_ADD, 5'd2, 5'd0, 5'd11, 32'h20);
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_pc !== 32'h700 || bus.ex_opcode !== OP_ADD ||
            bus.ex_imm !== 32'h20 || bus.ex_rd !== 5'd11) begin
            errors++;
            $display("FAIL stall_release: valid=%b pc=%h op=%b imm=%h rd=%0d exp 1/700/ADDI/20/11",
                     bus.ex_valid, bus.ex_pc, bus.ex_opcode, bus.ex_imm, bus.ex_rd);
        end
    endtask

    task automatic test_bubble_cnt();
        logic [1:0] exp_cnt;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        set_id(1'b1, 32'h800, OP_ADD, 5'd1, 5'd0, 5'd2, 32'h1);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.stall = 1'b0;
        checks++;
        if (bus.ex_bubble_cnt !== 2'd0) begin
            errors++;
            $display("FAIL cnt_flush_stalled: got %0d exp 0", bus.ex_bubble_cnt);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
`ifdef ID_EX_BUBBLE_CNT_EN
            exp_cnt = (i > 3) ? 2'd3 : 2'(i);
`else
            exp_cnt = 2'd0;
`endif
            checks++;
            if (bus.ex_bubble_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL bubble_cnt[%0d]: got %0d exp %0d", i, bus.ex_bubble_cnt, exp_cnt);
            end
        end
        bus.flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_decode();
        test_load_use();
        test_back_to_back();
        test_no_false_hazard();
        test_flush_hazard();
        test_stall();
        test_bubble_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
